alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Two-entry pipeline around the combinational ALU.
- EX register: latches a decoded operation and drives ALU_DA/ALU_DB/ALU_CTL/ALU_SHIFT.
- WB register: captures ALU_DC/ALU_OverFlow and presents them to writeback.
- Valid/ready handshakes on both sides; operand forwarding from EX and WB resolves back-to-back register dependencies.

Parameters:
- DATA_W, 16, operand/result width (matches ALU).
- CTL_W, 3, ALU operation code width.
- SHIFT_W, 4, shift amount width.
- REG_AW, 3, register index width; index 0 is the hardwired-zero register.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ID_VALID  in  1  decode presents an operation.
- ID_READY  out  1  stage accepts this cycle.
- ID_DA, ID_DB  in  DATA_W  register-file operands.
- ID_CTL  in  CTL_W  ALU op.
- ID_SHIFT  in  SHIFT_W  shift amount.
- ID_RS1, ID_RS2  in  REG_AW  source indices for DA/DB.
- ID_RD  in  REG_AW  destination index.
- ID_WE  in  1  operation writes RD.
- ALU_DA, ALU_DB  out  DATA_W  registered operands to ALU.
- ALU_CTL  out  CTL_W  registered op.
- ALU_SHIFT  out  SHIFT_W  registered shift.
- ALU_DC  in  DATA_W  ALU result (combinational from ALU_* outputs).
- ALU_OverFlow  in  1  ALU overflow.
- WB_VALID  out  1  result available.
- WB_READY  in  1  writeback consumes.
- WB_DATA  out  DATA_W  result.
- WB_RD  out  REG_AW  destination.
- WB_WE  out  1  write enable.
- WB_OVF  out  1  overflow of this result.
- OVF_STICKY  out  1  set by any retired overflow.
- OVF_CLR  in  1  clears OVF_STICKY.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - ex_valid=0, WB_VALID=0.
  - ALU_DA/DB/CTL/SHIFT=0.
  - WB_DATA/RD/WE/OVF=0, OVF_STICKY=0.
  - In-flight operations are discarded.
- Advance rules:
  - wb_adv = ex_valid & (!WB_VALID | WB_READY).
  - ID_READY = !ex_valid | wb_adv, further gated by the stall term (see Optional Feature).
- Accept: ID_VALID & ID_READY at edge N → EX loaded, ALU_* valid from N+1.
- WB capture:
  - On wb_adv, WB_DATA←ALU_DC, WB_OVF←ALU_OverFlow, WB_RD/WB_WE←EX copies, WB_VALID←1.
  - Else if WB_READY, WB_VALID←0.
  - Latency ID accept → WB_VALID = 2 cycles; throughput 1/cycle with WB_READY held high.
- Backpressure:
  - WB_VALID & !WB_READY holds WB and EX stable (ALU_* unchanged); ID_READY=0 while EX full.
- EX with no accept and no advance: ALU_* outputs hold last values.
  - ex_valid clears when EX drains with no new accept.
- Forwarding, per operand, on accept (RS=0 never forwarded):
  - Priority 1: EX match (ex_valid, ex_we, ex_rd==RS) → use ALU_DC.
  - Priority 2: WB match (WB_VALID, WB_WE, WB_RD==RS) → use WB_DATA.
  - Otherwise use ID_D*.
  - Matches are evaluated against the EX/WB contents before the clock edge.
- OVF_STICKY:
  - Set when WB_VALID & WB_READY & WB_OVF.
  - OVF_CLR clears it; a same-cycle set wins over clear.
- Simultaneous events:
  - WB retire, EX→WB advance and ID→EX accept may all occur in one cycle; no bubble is inserted.

Optional Feature:
- Macro ALU_FWD_EN.
- Defined: forwarding as above; no stall term.
- Undefined:
  - No forwarding; EX always loads ID_D*.
  - Stall term: ID_READY forced 0 while RS1/RS2 (non-zero) matches a valid EX or WB entry with WE=1.
  - Dependent op issues 1 cycle after the producer retires from WB.

Decomposition:
- Shared package alu_pkg: DATA_W/CTL_W/SHIFT_W/REG_AW constants and ALU_CTL opcode localparams.
- Sub-module alu_fwd_mux: per-operand forward select, instantiated twice.
- Stall logic lives in the top module.

Test Plan:
- Single op: ID_DA=16'hfff0, ID_DB=16'h0ff0, CTL=3'b010, RS=1/2, RD=3, WB_READY=1.
  - ALU_DA=16'hfff0, ALU_DB=16'h0ff0 at N+1.
  - WB_VALID=1 at N+2 with WB_DATA=ALU_DC sampled at N+1.
  - WB_RD=3.
- Back-to-back dependency: op1 RD=3; op2 RS1=3 next cycle with ID_DA=16'h0000.
  - With ALU_FWD_EN, op2's ALU_DA equals op1's result, no stall.
  - Without it, ID_READY low 2 cycles, then op2 issues with ID_DA.
- WB forward: op1 RD=5, bubble, op2 RS2=5 → ALU_DB=WB_DATA; RS2=0 with WB_RD=0 is never forwarded.
- Backpressure: WB_READY=0 for 3 cycles with 3 ops offered.
  - WB and ALU_* are stable and ID_READY=0 after EX fills.
  - Releasing WB_READY retires all ops in order, one per cycle.
- Overflow: op producing ALU_OverFlow=1 retires → OVF_STICKY=1.
  - OVF_CLR in the same cycle as a second overflow retire → remains 1.
  - OVF_CLR alone → 0.
- Reset mid-flight: rst_n low while EX and WB are full.
  - WB_VALID, ALU_* and OVF_STICKY go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the ALU issue stage.
//   DATA_W  : operand/result width
//   CTL_W   : ALU operation code width
//   SHIFT_W : shift amount width
//   REG_AW  : register index width (index 0 is the hardwired-zero register)
// Also holds the ALU opcode encodings, the operand-source enum and a helper
// that tests one pipeline entry for a register dependency.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int CTL_W   = 3;
  localparam int SHIFT_W = 4;
  localparam int REG_AW  = 3;

  // ALU operation codes driven on ALU_CTL.
  localparam logic [CTL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [CTL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [CTL_W-1:0] ALU_AND = 3'd2;
  localparam logic [CTL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [CTL_W-1:0] ALU_XOR = 3'd4;
  localparam logic [CTL_W-1:0] ALU_SLL = 3'd5;
  localparam logic [CTL_W-1:0] ALU_SRL = 3'd6;
  localparam logic [CTL_W-1:0] ALU_NOT = 3'd7;

  // Where an operand comes from when an operation is accepted into EX.
  typedef enum logic [1:0] {
    SRC_ID = 2'd0,   // register-file value from decode
    SRC_EX = 2'd1,   // result currently being computed by the ALU
    SRC_WB = 2'd2    // result waiting in the writeback register
  } fwd_src_e;

  // True when a valid, writing entry targets the (non-zero) source register.
  function automatic logic fwd_match(input logic              valid,
                                     input logic              we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return valid && we && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// -----------------------------------------------------------------------------
// alu_fwd_mux
// Per-operand dependency check against the EX and WB entries. Produces the
// operand source selection; the top uses it either to steer forwarded data
// (ALU_FWD_EN defined) or to raise a stall (ALU_FWD_EN undefined).
// Ports:
//   rs_i        source register index of the operand being decoded
//   ex_valid_i  EX entry valid        ex_we_i / ex_rd_i  EX destination
//   wb_valid_i  WB entry valid        wb_we_i / wb_rd_i  WB destination
//   src_o       selected source: SRC_EX has priority over SRC_WB
// -----------------------------------------------------------------------------
module alu_fwd_mux
  import alu_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic              ex_valid_i,
  input  logic              ex_we_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              wb_valid_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output fwd_src_e          src_o
);

  // The EX entry is the younger producer, so it wins over WB.
  always_comb begin
    src_o = SRC_ID;
    if (fwd_match(ex_valid_i, ex_we_i, ex_rd_i, rs_i)) begin
      src_o = SRC_EX;
    end else if (fwd_match(wb_valid_i, wb_we_i, wb_rd_i, rs_i)) begin
      src_o = SRC_WB;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Two-entry pipeline wrapped around an external combinational ALU.
//   EX register : holds the accepted operation and drives ALU_DA/DB/CTL/SHIFT.
//   WB register : captures ALU_DC/ALU_OverFlow and presents them to writeback.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   ID_VALID/ID_READY                  decode handshake
//   ID_DA/DB, ID_CTL, ID_SHIFT         operands and operation from decode
//   ID_RS1/RS2, ID_RD, ID_WE           source/destination register info
//   ALU_DA/DB, ALU_CTL, ALU_SHIFT      registered ALU inputs
//   ALU_DC, ALU_OverFlow               ALU result, combinational from ALU_*
//   WB_VALID/WB_READY                  writeback handshake
//   WB_DATA, WB_RD, WB_WE, WB_OVF      retired result
//   OVF_STICKY, OVF_CLR                accumulated overflow flag and its clear
// Configuration macro: ALU_FWD_EN
//   defined   : EX/WB results are forwarded into the accepted operands.
//   undefined : operands always come from decode; a dependent operation is
//               held off (ID_READY=0) until its producer has retired.
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ID_VALID,
  output logic               ID_READY,
  input  logic [DATA_W-1:0]  ID_DA,
  input  logic [DATA_W-1:0]  ID_DB,
  input  logic [CTL_W-1:0]   ID_CTL,
  input  logic [SHIFT_W-1:0] ID_SHIFT,
  input  logic [REG_AW-1:0]  ID_RS1,
  input  logic [REG_AW-1:0]  ID_RS2,
  input  logic [REG_AW-1:0]  ID_RD,
  input  logic               ID_WE,
  output logic [DATA_W-1:0]  ALU_DA,
  output logic [DATA_W-1:0]  ALU_DB,
  output logic [CTL_W-1:0]   ALU_CTL,
  output logic [SHIFT_W-1:0] ALU_SHIFT,
  input  logic [DATA_W-1:0]  ALU_DC,
  input  logic               ALU_OverFlow,
  output logic               WB_VALID,
  input  logic               WB_READY,
  output logic [DATA_W-1:0]  WB_DATA,
  output logic [REG_AW-1:0]  WB_RD,
  output logic               WB_WE,
  output logic               WB_OVF,
  output logic               OVF_STICKY,
  input  logic               OVF_CLR
);

  // EX entry
  logic               ex_valid_q, ex_valid_d;
  logic               ex_we_q,    ex_we_d;
  logic [REG_AW-1:0]  ex_rd_q,    ex_rd_d;
  logic [DATA_W-1:0]  alu_da_q,   alu_da_d;
  logic [DATA_W-1:0]  alu_db_q,   alu_db_d;
  logic [CTL_W-1:0]   alu_ctl_q,  alu_ctl_d;
  logic [SHIFT_W-1:0] alu_sh_q,   alu_sh_d;

  // WB entry
  logic               wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]  wb_data_q,  wb_data_d;
  logic [REG_AW-1:0]  wb_rd_q,    wb_rd_d;
  logic               wb_we_q,    wb_we_d;
  logic               wb_ovf_q,   wb_ovf_d;
  logic               sticky_q,   sticky_d;

  logic wb_adv;
  logic id_acc;
  logic stall;

  // Per-operand views, index 0 = DA/RS1, index 1 = DB/RS2.
  logic [REG_AW-1:0] rs_arr   [2];
  logic [DATA_W-1:0] id_d_arr [2];
  logic [DATA_W-1:0] opnd_arr [2];
  fwd_src_e          src_arr  [2];

  assign rs_arr[0]   = ID_RS1;
  assign rs_arr[1]   = ID_RS2;
  assign id_d_arr[0] = ID_DA;
  assign id_d_arr[1] = ID_DB;

`ifndef ALU_FWD_EN
  logic [1:0] hit;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      alu_fwd_mux u_fwd_mux (
        .rs_i       (rs_arr[gi]),
        .ex_valid_i (ex_valid_q),
        .ex_we_i    (ex_we_q),
        .ex_rd_i    (ex_rd_q),
        .wb_valid_i (wb_valid_q),
        .wb_we_i    (wb_we_q),
        .wb_rd_i    (wb_rd_q),
        .src_o      (src_arr[gi])
      );
`ifdef ALU_FWD_EN
      // ALU_DC is the value EX will hand to WB at this same edge.
      assign opnd_arr[gi] = (src_arr[gi] == SRC_EX) ? ALU_DC    :
                            (src_arr[gi] == SRC_WB) ? wb_data_q :
                                                      id_d_arr[gi];
`else
      assign opnd_arr[gi] = id_d_arr[gi];
      assign hit[gi]      = (src_arr[gi] != SRC_ID);
`endif
    end
  endgenerate

`ifdef ALU_FWD_EN
  assign stall = 1'b0;
`else
  // Hold a dependent op until the producer has left WB; a producer retiring
  // this very cycle still blocks, so the consumer issues one cycle later.
  assign stall = |hit;
`endif

  // EX may move on whenever WB is empty or being drained this cycle.
  assign wb_adv   = ex_valid_q && (!wb_valid_q || WB_READY);
  assign ID_READY = (!ex_valid_q || wb_adv) && !stall;
  assign id_acc   = ID_VALID && ID_READY;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_we_d    = ex_we_q;
    ex_rd_d    = ex_rd_q;
    alu_da_d   = alu_da_q;
    alu_db_d   = alu_db_q;
    alu_ctl_d  = alu_ctl_q;
    alu_sh_d   = alu_sh_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_ovf_d   = wb_ovf_q;
    sticky_d   = sticky_q;

    if (id_acc) begin
      ex_valid_d = 1'b1;
      ex_we_d    = ID_WE;
      ex_rd_d    = ID_RD;
      alu_da_d   = opnd_arr[0];
      alu_db_d   = opnd_arr[1];
      alu_ctl_d  = ID_CTL;
      alu_sh_d   = ID_SHIFT;
    end else if (wb_adv) begin
      // Drained with nothing new: ALU_* keep their last values.
      ex_valid_d = 1'b0;
    end

    if (wb_adv) begin
      wb_valid_d = 1'b1;
      wb_data_d  = ALU_DC;
      wb_ovf_d   = ALU_OverFlow;
      wb_rd_d    = ex_rd_q;
      wb_we_d    = ex_we_q;
    end else if (WB_READY) begin
      wb_valid_d = 1'b0;
    end

    // A retiring overflow takes precedence over a clear in the same cycle.
    if (wb_valid_q && WB_READY && wb_ovf_q) begin
      sticky_d = 1'b1;
    end else if (OVF_CLR) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_rd_q    <= '0;
      alu_da_q   <= '0;
      alu_db_q   <= '0;
      alu_ctl_q  <= '0;
      alu_sh_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_ovf_q   <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_we_q    <= ex_we_d;
      ex_rd_q    <= ex_rd_d;
      alu_da_q   <= alu_da_d;
      alu_db_q   <= alu_db_d;
      alu_ctl_q  <= alu_ctl_d;
      alu_sh_q   <= alu_sh_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_ovf_q   <= wb_ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign ALU_DA     = alu_da_q;
  assign ALU_DB     = alu_db_q;
  assign ALU_CTL    = alu_ctl_q;
  assign ALU_SHIFT  = alu_sh_q;
  assign WB_VALID   = wb_valid_q;
  assign WB_DATA    = wb_data_q;
  assign WB_RD      = wb_rd_q;
  assign WB_WE      = wb_we_q;
  assign WB_OVF     = wb_ovf_q;
  assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Bench for alu_issue_stage with a behavioural ALU attached to ALU_* and a
// scoreboard of expected writeback results. Honours ALU_FWD_EN the same way
// the design does.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_VALID, ID_READY;
  logic [15:0] ID_DA, ID_DB;
  logic [2:0]  ID_CTL;
  logic [3:0]  ID_SHIFT;
  logic [2:0]  ID_RS1, ID_RS2, ID_RD;
  logic        ID_WE;
  logic [15:0] ALU_DA, ALU_DB;
  logic [2:0]  ALU_CTL;
  logic [3:0]  ALU_SHIFT;
  logic [15:0] ALU_DC;
  logic        ALU_OverFlow;
  logic        WB_VALID, WB_READY;
  logic [15:0] WB_DATA;
  logic [2:0]  WB_RD;
  logic        WB_WE, WB_OVF;
  logic        OVF_STICKY, OVF_CLR;

  int total = 0;
  int bad   = 0;
  int last_stall;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        we;
    logic        ovf;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_DA(ID_DA), .ID_DB(ID_DB), .ID_CTL(ID_CTL), .ID_SHIFT(ID_SHIFT),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_WE(ID_WE),
    .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALU_CTL(ALU_CTL), .ALU_SHIFT(ALU_SHIFT),
    .ALU_DC(ALU_DC), .ALU_OverFlow(ALU_OverFlow),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_DATA(WB_DATA), .WB_RD(WB_RD), .WB_WE(WB_WE), .WB_OVF(WB_OVF),
    .OVF_STICKY(OVF_STICKY), .OVF_CLR(OVF_CLR)
  );

  // Behavioural ALU: {overflow, result}
  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] c, input logic [3:0] s);
    logic [15:0] r;
    logic        o;
    o = 1'b0;
    case (c)
      3'd0: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << s;
      3'd6: r = a >> s;
      default: r = ~a;
    endcase
    return {o, r};
  endfunction

  assign {ALU_OverFlow, ALU_DC} = alu_f(ALU_DA, ALU_DB, ALU_CTL, ALU_SHIFT);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Operand value the accepted op should see: youngest in-flight producer
  // when forwarding, otherwise the decode value.
  function automatic logic [15:0] opnd_val(input logic [2:0] rs, input logic [15:0] d);
    logic [15:0] v;
    v = d;
`ifdef ALU_FWD_EN
    if (rs != 3'd0)
      for (int i = 0; i < sbq.size(); i++)
        if (sbq[i].we && sbq[i].rd == rs) v = sbq[i].data;
`else
    v = d + 16'd0 + {13'd0, rs & 3'd0};
`endif
    return v;
  endfunction

  // Monitor: sample between edges; forwarding view is taken before retirement.
  always @(negedge clk) begin
    exp_t        e, r;
    logic [16:0] res;
    logic        acc;
    if (rst_n) begin
      acc = ID_VALID && ID_READY;
      if (acc) begin
        res  = alu_f(opnd_val(ID_RS1, ID_DA), opnd_val(ID_RS2, ID_DB), ID_CTL, ID_SHIFT);
        e.data = res[15:0];
        e.ovf  = res[16];
        e.rd   = ID_RD;
        e.we   = ID_WE;
      end
      if (WB_VALID && WB_READY) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_retire", 1, 0);
        end else begin
          r = sbq.pop_front();
          check("wb_data", WB_DATA, r.data);
          check("wb_rd",   WB_RD,   r.rd);
          check("wb_we",   WB_WE,   r.we);
          check("wb_ovf",  WB_OVF,  r.ovf);
          $display("retire data=%h rd=%0d we=%0d ovf=%0d", WB_DATA, WB_RD, WB_WE, WB_OVF);
        end
      end
      if (acc) sbq.push_back(e);
    end
  end

  task automatic send(input logic [15:0] da, input logic [15:0] db, input logic [2:0] ctl,
                      input logic [3:0] sh, input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic [2:0] rd, input logic we);
    int n;
    ID_DA = da; ID_DB = db; ID_CTL = ctl; ID_SHIFT = sh;
    ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd; ID_WE = we;
    ID_VALID = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ID_READY) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    ID_VALID = 1'b0;
    last_stall = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 || WB_VALID) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        check("drain_timeout", 1, 0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_stall;
    rst_n = 1'b0; ID_VALID = 1'b0; ID_DA = '0; ID_DB = '0; ID_CTL = '0; ID_SHIFT = '0;
    ID_RS1 = '0; ID_RS2 = '0; ID_RD = '0; ID_WE = 1'b0; WB_READY = 1'b1; OVF_CLR = 1'b0;
    #12;
    check("rst_wb_valid", WB_VALID, 0);
    check("rst_alu", {ALU_DA, ALU_DB, ALU_CTL, ALU_SHIFT}, 0);
    check("rst_wb", {WB_DATA, WB_RD, WB_WE, WB_OVF, OVF_STICKY}, 0);
    check("rst_id_ready", ID_READY, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op, latency 2
    send(16'hfff0, 16'h0ff0, 3'b010, 4'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    check("single_alu_da", ALU_DA, 16'hfff0);
    check("single_alu_db", ALU_DB, 16'h0ff0);
    check("single_wbv_n1", WB_VALID, 0);
    @(posedge clk); #1;
    check("single_wbv_n2", WB_VALID, 1);
    check("single_wb_data", WB_DATA, 16'h0ff0);
    check("single_wb_rd", WB_RD, 3'd3);
    drain();

    // Back-to-back EX dependency
    send(16'h1234, 16'h0101, 3'd0, 4'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    send(16'h0000, 16'h0001, 3'd0, 4'd0, 3'd3, 3'd0, 3'd4, 1'b1);
`ifdef ALU_FWD_EN
    check("b2b_stall", last_stall, 0);
    check("b2b_alu_da", ALU_DA, 16'h1335);
`else
    check("b2b_stall", last_stall, 2);
    check("b2b_alu_da", ALU_DA, 16'h0000);
`endif
    drain();

    // WB dependency after a bubble
    send(16'h00ff, 16'h0001, 3'd0, 4'd0, 3'd1, 3'd2, 3'd5, 1'b1);
    @(posedge clk); #1;
    send(16'h0000, 16'h0000, 3'd3, 4'd0, 3'd0, 3'd5, 3'd6, 1'b1);
`ifdef ALU_FWD_EN
    check("wbf_stall", last_stall, 0);
    check("wbf_alu_db", ALU_DB, 16'h0100);
`else
    check("wbf_stall", last_stall, 1);
    check("wbf_alu_db", ALU_DB, 16'h0000);
`endif
    drain();

    // Register 0 in WB is never forwarded nor stalls
    send(16'h1111, 16'h2222, 3'd0, 4'd0, 3'd1, 3'd2, 3'd0, 1'b1);
    @(posedge clk); #1;
    send(16'h0000, 16'h0abc, 3'd3, 4'd0, 3'd0, 3'd0, 3'd7, 1'b1);
    check("r0_stall", last_stall, 0);
    check("r0_alu_db", ALU_DB, 16'h0abc);
    drain();

    // Random mix, scoreboard only
    for (int i = 0; i < 12; i++) begin
      send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end
    drain();

    // Throughput with independent ops
    exp_stall = 0;
    for (int i = 0; i < 4; i++) begin
      send(16'(i * 3 + 1), 16'(i + 7), 3'd4, 4'd0, 3'd1, 3'd2, 3'(4 + (i % 3)), 1'b0);
      exp_stall += last_stall;
    end
    check("thru_stalls", exp_stall, 0);
    drain();

    // Backpressure
    WB_READY = 1'b0;
    send(16'h0001, 16'h0002, 3'd0, 4'd0, 3'd1, 3'd2, 3'd4, 1'b1);
    send(16'h0010, 16'h0020, 3'd0, 4'd0, 3'd1, 3'd2, 3'd5, 1'b1);
    fork
      send(16'h0100, 16'h0200, 3'd0, 4'd0, 3'd1, 3'd2, 3'd6, 1'b1);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_id_ready", ID_READY, 0);
          check("bp_wb_hold", {WB_VALID, WB_DATA, WB_RD}, {1'b1, 16'h0003, 3'd4});
          check("bp_alu_hold", {ALU_DA, ALU_DB}, {16'h0010, 16'h0020});
        end
        @(posedge clk); #1;
        WB_READY = 1'b1;
      end
    join
    check("bp_rel_wbv0", WB_VALID, 1);
    @(posedge clk); #1;
    check("bp_rel_wbv1", WB_VALID, 1);
    @(posedge clk); #1;
    check("bp_rel_wbv2", WB_VALID, 0);
    drain();

    // Overflow sticky
    send(16'h7fff, 16'h0001, 3'd0, 4'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    drain();
    check("ovf_set", OVF_STICKY, 1);
    send(16'h8000, 16'hffff, 3'd0, 4'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    @(posedge clk); #1;
    OVF_CLR = 1'b1;
    @(posedge clk); #1;
    OVF_CLR = 1'b0;
    check("ovf_set_beats_clr", OVF_STICKY, 1);
    drain();
    OVF_CLR = 1'b1;
    @(posedge clk); #1;
    OVF_CLR = 1'b0;
    check("ovf_clr", OVF_STICKY, 0);

    // Reset mid-flight
    send(16'h7fff, 16'h7fff, 3'd0, 4'd0, 3'd1, 3'd2, 3'd3, 1'b1);
    drain();
    check("pre_rst_sticky", OVF_STICKY, 1);
    WB_READY = 1'b0;
    send(16'h0005, 16'h0006, 3'd0, 4'd1, 3'd1, 3'd2, 3'd4, 1'b1);
    send(16'h0007, 16'h0008, 3'd1, 4'd2, 3'd1, 3'd2, 3'd5, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    check("mid_rst_wbv", WB_VALID, 0);
    check("mid_rst_alu", {ALU_DA, ALU_DB, ALU_CTL, ALU_SHIFT}, 0);
    check("mid_rst_sticky", OVF_STICKY, 0);
    WB_READY = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0042, 16'h0001, 3'd1, 4'd0, 3'd1, 3'd2, 3'd2, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
